calc_btn_cond: RTL
==================

// Module: calc_btn_cond
// PURPOSE
// - Conditions the five raw pushbuttons before they reach the calculator top (calc).
// - Per button: 2-flop synchroniser, then counter-based debouncer.
// - btnl/btnr/btnd leave as clean debounced levels; they drive the op encoder.
// - btnc/btnac leave as single-cycle pulses, so one physical press gives exactly one
//   accumulator load or clear.
// PARAMETERS
// - SYNC_STAGES  default 2          synchroniser depth (>=2)
// - DEB_CYCLES   default 1_000_000  consecutive stable cycles to accept a change (10 ms @ 100 MHz)
// - CNT_W        default $clog2(DEB_CYCLES+1)  debounce counter width (derived, not overridden)
// PORTS
// - clk          in   1  system clock
// - rst          in   1  asynchronous, active-high reset
// - btnc_raw     in   1  raw centre button (load)
// - btnac_raw    in   1  raw all-clear button
// - btnl_raw     in   1  raw left button
// - btnr_raw     in   1  raw right button
// - btnd_raw     in   1  raw down button
// - btnc_pulse   out  1  one-cycle load strobe, drives calc.btnc
// - btnac_pulse  out  1  one-cycle clear strobe, drives calc.btnac
// - btnl         out  1  debounced level, drives calc.btnl
// - btnr         out  1  debounced level, drives calc.btnr
// - btnd         out  1  debounced level, drives calc.btnd
// BEHAVIOUR
// - Interface: one clock, clk; reset is asynchronous and active-high, rst.
// - Reset:
//   - All sync flops, counters and debounced levels clear to 0.
//   - All outputs are 0 while rst is high and on the first edge after release.
//   - Asserting rst mid-count discards the partial count.
// - Synchroniser: raw -> SYNC_STAGES flops -> s. Nothing downstream reads raw inputs.
// - Debouncer state per button: deb (level), cnt (CNT_W bits).
//   - s == deb: cnt <= 0.
//   - s != deb and cnt < DEB_CYCLES-1: cnt <= cnt+1.
//   - s != deb and cnt == DEB_CYCLES-1: deb <= s, cnt <= 0.
//   - Any glitch back to deb restarts the count from 0. cnt never wraps.
// - Latency: a clean raw step at edge 0 shows on deb at edge SYNC_STAGES+DEB_CYCLES.
// - Pulses:
//   - btnX_pulse is registered and high for exactly one cycle, on the edge where deb
//     goes 0->1. Nothing on release.
//   - A held button gives one pulse only.
// - Priority: if btnac and btnc pulses would fire on the same edge, btnac_pulse fires and
//   btnc_pulse is dropped, not deferred.
// - Op stability:
//   - btnl/btnr/btnd are the deb levels directly.
//   - btnc_pulse is additionally suppressed while any of the l/r/d counters is non-zero,
//     so the op code never changes in the load cycle.
//   - A suppressed load is dropped, not deferred.
// - No combinational path from any input to any output.
// STRUCTURE
// - Shared package calc_pkg: DEB_CYCLES default and the button index enum
//   BTN_C, BTN_AC, BTN_L, BTN_R, BTN_D (3 bits). The package also holds the ALU op codes.
// - Sub-module btn_debounce (sync + counter + deb + rise pulse), instanced 5x via generate.
// - Top module handles the ac/c priority and the op-stability gating only.
// - Target size about 150 lines total.
// TESTING (DEB_CYCLES=4, SYNC_STAGES=2)
// - Reset: rst=1 with all raw=1 -> all outputs 0. Release rst with raw held at 1
//   -> btnc_pulse high exactly at edge 6, then 0 forever.
// - Bounce: btnc_raw 1,0,1,1,0, then steady 1 -> exactly one btnc_pulse,
//   6 edges after the last 0->1 edge.
// - Short press: btnl_raw high for 3 cycles -> btnl stays 0 and cnt returns to 0.
// - Simultaneous press: btnc_raw and btnac_raw rise on the same edge -> btnac_pulse=1,
//   btnc_pulse=0 on that edge; no later btnc pulse.
// - Op gating: btnr_raw toggles 2 cycles before btnc would fire -> btnc_pulse suppressed.
//   Repeat with btnr stable -> pulse at the expected edge.
// - Mid-operation reset: assert rst when btnd cnt==2 -> btnd=0 and cnt=0 immediately
//   (async). After release, a steady raw=1 needs the full 6 edges again.

Source files
------------

// File: rtl/calc_pkg.sv
// rtl/calc_pkg.sv - shared calculator constants: debounce default, button indices, ALU op codes
package calc_pkg;

  localparam int DEB_CYCLES_DEF = 1_000_000;

  typedef enum logic [2:0] {
    BTN_C  = 3'd0,
    BTN_AC = 3'd1,
    BTN_L  = 3'd2,
    BTN_R  = 3'd3,
    BTN_D  = 3'd4
  } btn_idx_e;

  typedef enum logic [1:0] {
    OP_ADD = 2'd0,
    OP_SUB = 2'd1,
    OP_AND = 2'd2,
    OP_OR  = 2'd3
  } alu_op_e;

endpackage

// File: rtl/btn_debounce.sv
// rtl/btn_debounce.sv - one button: synchroniser, stability counter, debounced level, rise strobe
module btn_debounce #(
  parameter int SYNC_STAGES = 2,
  parameter int DEB_CYCLES  = 1_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic deb,
  output logic rise,
  output logic busy
);

  localparam int CNT_W = $clog2(DEB_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEB_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync;
  logic [CNT_W-1:0]       cnt;
  logic                   s;

  assign s = sync[SYNC_STAGES-1];

  // Asserted in the cycle before deb goes 0->1; the top registers it as the pulse.
  assign rise = s & ~deb & (cnt == CNT_LAST);
  assign busy = (cnt != '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync <= '0;
      cnt  <= '0;
      deb  <= 1'b0;
    end else begin
      sync <= {sync[SYNC_STAGES-2:0], raw};
      if (s == deb) begin
        cnt <= '0;
      end else if (cnt == CNT_LAST) begin
        deb <= s;
        cnt <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/calc_btn_cond.sv
// rtl/calc_btn_cond.sv - conditions the five calculator pushbuttons into clean levels and strobes
module calc_btn_cond
  import calc_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int DEB_CYCLES  = DEB_CYCLES_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic btnc_raw,
  input  logic btnac_raw,
  input  logic btnl_raw,
  input  logic btnr_raw,
  input  logic btnd_raw,
  output logic btnc_pulse,
  output logic btnac_pulse,
  output logic btnl,
  output logic btnr,
  output logic btnd
);

  logic [4:0] raw_vec;
  logic [4:0] deb_vec;
  logic [4:0] rise_vec;
  logic [4:0] busy_vec;
  logic       op_busy;
  logic       unused_sig;

  always_comb begin
    raw_vec         = '0;
    raw_vec[BTN_C]  = btnc_raw;
    raw_vec[BTN_AC] = btnac_raw;
    raw_vec[BTN_L]  = btnl_raw;
    raw_vec[BTN_R]  = btnr_raw;
    raw_vec[BTN_D]  = btnd_raw;
  end

  for (genvar i = 0; i < 5; i++) begin : g_btn
    btn_debounce #(
      .SYNC_STAGES(SYNC_STAGES),
      .DEB_CYCLES (DEB_CYCLES)
    ) u_deb (
      .clk (clk),
      .rst (rst),
      .raw (raw_vec[i]),
      .deb (deb_vec[i]),
      .rise(rise_vec[i]),
      .busy(busy_vec[i])
    );
  end

  assign btnl = deb_vec[BTN_L];
  assign btnr = deb_vec[BTN_R];
  assign btnd = deb_vec[BTN_D];

  // A pending op-button change means the op code may move; drop the load rather than race it.
  assign op_busy = busy_vec[BTN_L] | busy_vec[BTN_R] | busy_vec[BTN_D];

  assign unused_sig = &{1'b0, deb_vec[BTN_C], deb_vec[BTN_AC], busy_vec[BTN_C], busy_vec[BTN_AC],
                        rise_vec[BTN_L], rise_vec[BTN_R], rise_vec[BTN_D]};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      btnac_pulse <= 1'b0;
      btnc_pulse  <= 1'b0;
    end else begin
      btnac_pulse <= rise_vec[BTN_AC];
      btnc_pulse  <= rise_vec[BTN_C] & ~rise_vec[BTN_AC] & ~op_busy;
    end
  end

endmodule
